// File: rtl/debounce_sync.sv
// debounce_sync
//   Cleans up a raw, asynchronous, bouncy single-bit input such as a push-button
//   or a switch. It has three parts:
//   - a SYNC_STAGES-deep synchronizer chain;
//   - a four-state filter FSM with a stability counter;
//   - optional one-cycle edge strobes.
//   The output o_q changes only after the synchronized input has disagreed with
//   it for STABLE_COUNT consecutive clock edges.
//
// Parameters
//   SYNC_STAGES  : synchronizer depth (>= 2)
//   STABLE_COUNT : consecutive mismatching edges needed to accept a new level (>= 1)
//   CNT_WIDTH    : stability counter width; requires 2**CNT_WIDTH > STABLE_COUNT-1
//
// Ports
//   i_clk   in  : clock; all state updates on its rising edge
//   i_rst_n in  : asynchronous reset, active-low
//   i_d     in  : raw asynchronous input
//   o_q     out : debounced level (direct flop output)
//   o_rise  out : one-cycle strobe on an accepted 0->1 change of o_q
//   o_fall  out : one-cycle strobe on an accepted 1->0 change of o_q
//
// Build option
//   DEBOUNCE_SYNC_EDGE_EN : when defined, the o_rise/o_fall registers are built;
//                           otherwise both outputs are tied to 0.

module debounce_sync #(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_COUNT = 50000,
  parameter int CNT_WIDTH    = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST     = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam bit                   ONE_SHOT = (STABLE_COUNT == 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;

  state_t                 state;
  state_t                 state_next;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   cnt_next;
  logic                   q;
  logic                   q_next;

  // Synchronizer: stage 0 samples i_d; the last stage is the only signal the
  // filter FSM reads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= LOW;
      cnt   <= '0;
      q     <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      q     <= q_next;
    end
  end

  // The stored counter equals (number of consecutive mismatch edges seen so far)
  // minus one. The edge that leaves LOW/HIGH is the first mismatch edge, so the
  // wait states accept on the edge where cnt+1 reaches STABLE_COUNT-1. That edge
  // is the STABLE_COUNT-th mismatch. With STABLE_COUNT=1 the first mismatch
  // accepts at once and the wait states are never entered.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    q_next     = q;
    case (state)
      LOW: begin
        cnt_next = '0;
        if (s) begin
          if (ONE_SHOT) begin
            state_next = HIGH;
            q_next     = 1'b1;
          end else begin
            state_next = RISE_WAIT;
          end
        end
      end
      RISE_WAIT: begin
        if (!s) begin
          state_next = LOW;
          cnt_next   = '0;
        end else if (cnt + CNT_ONE == LAST) begin
          state_next = HIGH;
          cnt_next   = '0;
          q_next     = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        cnt_next = '0;
        if (!s) begin
          if (ONE_SHOT) begin
            state_next = LOW;
            q_next     = 1'b0;
          end else begin
            state_next = FALL_WAIT;
          end
        end
      end
      FALL_WAIT: begin
        if (s) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else if (cnt + CNT_ONE == LAST) begin
          state_next = LOW;
          cnt_next   = '0;
          q_next     = 1'b0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = LOW;
        cnt_next   = '0;
        q_next     = 1'b0;
      end
    endcase
  end

  assign o_q = q;

`ifdef DEBOUNCE_SYNC_EDGE_EN
  logic rise;
  logic fall;

  // The strobes are registered from the same next-level decision that updates q.
  // They therefore rise on the edge where o_q toggles. Reset clears q directly,
  // so no strobe is produced because of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= q_next & ~q;
      fall <= ~q_next & q;
    end
  end

  assign o_rise = rise;
  assign o_fall = fall;
`else
  assign o_rise = 1'b0;
  assign o_fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync
//   Self-checking bench for debounce_sync with SYNC_STAGES=2 and STABLE_COUNT=4.
//   - The driver applies one input value per clock.
//   - For each value, a run-length reference model works out the expected
//     o_q/o_rise/o_fall after that edge and pushes the result into a queue.
//   - A monitor on the falling edge pops each entry and compares it with the DUT.
//   Directed scenarios come first, followed by randomized bursts with
//   occasional resets.

module tb_debounce_sync;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;
`ifdef DEBOUNCE_SYNC_EDGE_EN
  localparam int EDGE_EN = 1;
`else
  localparam int EDGE_EN = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic d     = 1'b0;
  logic q;
  logic rise;
  logic fall;

  always #5 clk = ~clk;

  debounce_sync #(
    .SYNC_STAGES (SYNC),
    .STABLE_COUNT(STABLE),
    .CNT_WIDTH   (16)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_d    (d),
    .o_q    (q),
    .o_rise (rise),
    .o_fall (fall)
  );

  typedef struct packed {
    logic q;
    logic rise;
    logic fall;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   rise_seen = 0;
  int   fall_seen = 0;

  // Reference model state.
  // - m_q is the accepted level.
  // - m_run is the length of the current run of edges whose synchronized input
  //   differs from m_q.
  // - m_pipe holds the raw samples that are still travelling through the
  //   synchronizer.
  logic m_q;
  int   m_run;
  logic m_pipe[$];

  task automatic chk(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_q   = 1'b0;
    m_run = 0;
    m_pipe.delete();
    for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b0);
    sb.delete();
  endtask

  // Works out what one clock edge, sampling din, does to the outputs.
  task automatic model_edge(input logic din);
    logic s;
    exp_t e;
    s = m_pipe.pop_front();
    m_pipe.push_back(din);
    e = '0;
    if (s != m_q) begin
      m_run++;
      if (m_run == STABLE) begin
        m_q    = ~m_q;
        m_run  = 0;
        e.rise = (EDGE_EN != 0) && m_q;
        e.fall = (EDGE_EN != 0) && !m_q;
      end
    end else begin
      m_run = 0;
    end
    e.q = m_q;
    sb.push_back(e);
  endtask

  // Applies one input value for the next edge. The call returns 1 time unit
  // after that edge.
  task automatic step(input logic din);
    d = din;
    model_edge(din);
    @(posedge clk);
    #1;
  endtask

  // Asserts reset between clock edges and checks that it acts at once.
  // Reset is then held for a number of edges and released just after a
  // falling edge.
  task automatic do_reset(input logic din, input int cycles);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    d     = din;
    #1;
    chk("rst_async_q", q, 1'b0);
    chk("rst_async_rise", rise, 1'b0);
    chk("rst_async_fall", fall, 1'b0);
    model_reset();
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Holds din until o_q follows it, or until a bound of 20 edges runs out.
  // Then checks how many edges that took, counting the first edge that
  // sampled din.
  task automatic measure_latency(input logic din, input int expn, input string name);
    int n;
    n = 0;
    do begin
      step(din);
      n++;
    end while (q !== din && n < 20);
    chk_int(name, n, expn);
  endtask

  // Monitor: compares the DUT against the queued expectation for the edge
  // just taken.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_q", q, 1'b0);
      chk("rst_rise", rise, 1'b0);
      chk("rst_fall", fall, 1'b0);
    end else if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("sb_q", q, mon_e.q);
      chk("sb_rise", rise, mon_e.rise);
      chk("sb_fall", fall, mon_e.fall);
      chk("rise_fall_excl", rise & fall, 1'b0);
      if (rise === 1'b1) rise_seen++;
      if (fall === 1'b1) fall_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0;
    int f0;
    int nsteps;
    int len;
    logic v;

    model_reset();

    // Scenario 1: power-up with i_d held at 1.
    do_reset(1'b1, 3);
    r0 = rise_seen;
    f0 = fall_seen;
    measure_latency(1'b1, SYNC + STABLE, "lat_powerup");
    repeat (4) step(1'b1);
    chk_int("s1_rise_count", rise_seen - r0, EDGE_EN);
    chk_int("s1_fall_count", fall_seen - f0, 0);

    // Scenario 2: a 3-cycle pulse is shorter than STABLE and is rejected.
    do_reset(1'b0, 2);
    repeat (6) step(1'b0);
    r0 = rise_seen;
    repeat (3) step(1'b1);
    repeat (10) step(1'b0);
    chk("s2_q_low", q, 1'b0);
    chk_int("s2_rise_count", rise_seen - r0, 0);

    // Scenario 3: bounce 1,0,1,0, then hold 1 from the final 0->1 sample.
    r0 = rise_seen;
    step(1'b1);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    measure_latency(1'b1, SYNC + STABLE, "lat_bounce");
    repeat (4) step(1'b1);
    chk_int("s3_rise_count", rise_seen - r0, EDGE_EN);

    // Scenario 4: falling qualification from HIGH.
    r0 = rise_seen;
    f0 = fall_seen;
    measure_latency(1'b0, SYNC + STABLE, "lat_fall");
    repeat (4) step(1'b0);
    chk_int("s4_fall_count", fall_seen - f0, EDGE_EN);
    chk_int("s4_rise_count", rise_seen - r0, 0);

    // Scenario 5a: reset in the middle of FALL_WAIT clears o_q at once.
    measure_latency(1'b1, SYNC + STABLE, "lat_rise_again");
    repeat (3) step(1'b1);
    repeat (4) step(1'b0);
    chk("s5_pre_reset_q", q, 1'b1);
    do_reset(1'b1, 2);
    measure_latency(1'b1, SYNC + STABLE, "lat_after_reset_hi");

    // Scenario 5b: reset in the middle of RISE_WAIT; qualification then
    // restarts from zero.
    do_reset(1'b0, 2);
    repeat (4) step(1'b0);
    repeat (4) step(1'b1);
    chk("s5b_pre_reset_q", q, 1'b0);
    do_reset(1'b1, 1);
    measure_latency(1'b1, SYNC + STABLE, "lat_after_reset_rw");

    // Randomized bursts. Burst lengths lie around STABLE so that both
    // rejection and acceptance are exercised; resets are occasional.
    nsteps = 0;
    while (nsteps < 800) begin
      len = $urandom_range(1, STABLE + 3);
      v   = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) step(v);
      nsteps += len;
      if ($urandom_range(0, 40) == 0) do_reset(1'($urandom_range(0, 1)), 1);
    end

    repeat (2) @(negedge clk);
    #1;
    chk_int("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
